alu_issuer: RTL and testbench
=============================

# alu_issuer

Instruction issue and writeback controller that drives the shared combinational `alu`. It accepts 16-bit register-to-register instructions over a valid/ready stream and holds an 8-entry register file. Each instruction reads its operands, presents opcode and operands to the ALU, and writes the result back. Every result is also returned on an output valid/ready stream, so this block is the initiator and owner of ALU operations in the datapath.

## Interface
- N, 32, datapath width; must be ≥ 10.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block can accept an instruction.
- in_instr  in  16  instruction fields:
  - [15:13] op
  - [12:10] rd
  - [9:7] ra
  - [6:4] rb
  - [3:0] ignored
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  N  result value.
- out_rd  out  3  destination register of the result.

## Operation
- Op codes 0–6 follow the ALU encoding: ADD, SUB, LESS, EQ, OR, AND, NOT.
  - ALU operands are op_a = R[ra] and op_b = R[rb].
  - NOT ignores rb.
  - LESS is an unsigned compare; LESS and EQ produce 0 or 1, zero-extended.
  - ADD and SUB wrap modulo 2^N.
- Op 7 is LI: op_a = zero-extended instr[9:0], op_b = 0, and the ALU is driven with ADD.
- Only one instruction is in flight at a time. No hazards are possible.
- FSM:
  - IDLE: in_ready=1. On in_valid, latch op, rd and both operands, then go to EXEC.
  - EXEC: the ALU output is registered into out_result, R[rd] is written, then go to RESP.
  - RESP: out_valid=1. On out_ready go to IDLE.
- The register write happens on the EXEC→RESP edge and is never undone by output backpressure.
- Reset values:
  - in_ready=0 during reset and 1 in the first cycle after reset.
  - out_valid=0, out_result=0, out_rd=0.
  - All registers are 0 and the state is IDLE.
- Reset asserted in any state drops the in-flight instruction. No writeback or out_valid occurs for it.

## Timing
- An input handshake in cycle t gives EXEC in cycle t+1 and out_valid in cycle t+2.
- An output handshake in cycle u gives in_ready=1 in cycle u+1.
- Peak throughput is one instruction per 3 cycles when out_ready is held high.
- While out_valid=1 and out_ready=0:
  - out_result and out_rd hold stable.
  - in_ready=0.
- in_instr is sampled only at the accepting edge and may change afterward.
- Operands are read from the register file at the accepting edge. Because a result is written before the next accept, that value is always visible to the next instruction.

## Configuration
- ALU_ISSUER_R0_ZERO_EN defined:
  - R0 always reads 0.
  - Writes with rd=0 are discarded.
  - out_result still reports the computed value and out_rd=0.
- Not defined: R0 is an ordinary writable register.

## Structure
- A shared package `alu_pkg` holds:
  - the ALU opcode constants (the existing defines, values 0–6);
  - OP_LI=7;
  - the instruction field positions.
- The existing `alu` module is instantiated with N passed through.
- Sub-module `alu_regfile`:
  - 8×N entries;
  - two combinational read ports and one synchronous write port;
  - synchronous reset to 0;
  - implements the R0_ZERO behaviour.

## Test plan
- Reset check: hold rst for 2 cycles, then observe in_ready=1 and out_valid=0. ADD r1,r2,r3 → out_result=0, out_rd=1, out_valid in the 2nd cycle after accept.
- Arithmetic and wrap: LI r1,5; LI r2,3; SUB r3,r1,r2 → 2. SUB r4,r2,r1 → 0xFFFFFFFE. LI r5,0x3FF; ADD r5,r5,r5 → 0x7FE.
- Compare and logic, with r1=5 and r2=3:
  - LESS r6,r2,r1 → 1.
  - LESS r6,r1,r2 → 0.
  - EQ r6,r1,r1 → 1.
  - OR r7,r1,r2 → 7.
  - AND r7,r1,r2 → 1.
  - NOT r7,r2 → 0xFFFFFFFC.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1. Expect out_valid to stay high, out_result stable, in_ready=0. Release out_ready; the next accept occurs exactly one cycle after the output handshake.
- Reset mid-op: LI r1,9, then assert rst during EXEC. Expect no out_valid. A subsequent ADD r2,r1,r0 → 0.
- Macro check: LI r0,7; ADD r1,r0,r0 → 0 with ALU_ISSUER_R0_ZERO_EN, 14 without.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, instruction field positions and issuer state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_LESS = 3'd2;
    localparam logic [2:0] ALU_EQ   = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_AND  = 3'd5;
    localparam logic [2:0] ALU_NOT  = 3'd6;
    localparam logic [2:0] OP_LI    = 3'd7;

    localparam int INSTR_OP_HI  = 15;
    localparam int INSTR_OP_LO  = 13;
    localparam int INSTR_RD_HI  = 12;
    localparam int INSTR_RD_LO  = 10;
    localparam int INSTR_RA_HI  = 9;
    localparam int INSTR_RA_LO  = 7;
    localparam int INSTR_RB_HI  = 6;
    localparam int INSTR_RB_LO  = 4;
    localparam int INSTR_IMM_HI = 9;
    localparam int INSTR_IMM_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } issue_state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU: add/sub wrap modulo 2^N, compares are unsigned and zero-extended.
module alu
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [2:0]   i_op,
    input  logic [N-1:0] i_op_a,
    input  logic [N-1:0] i_op_b,
    output logic [N-1:0] o_result
);

    always_comb begin
        // NOTE: default first so every path assigns o_result and no latch is inferred.
        o_result = '0;
        case (i_op)
            ALU_ADD:  o_result = i_op_a + i_op_b;
            ALU_SUB:  o_result = i_op_a - i_op_b;
            ALU_LESS: o_result = N'(i_op_a < i_op_b);
            ALU_EQ:   o_result = N'(i_op_a == i_op_b);
            ALU_OR:   o_result = i_op_a | i_op_b;
            ALU_AND:  o_result = i_op_a & i_op_b;
            ALU_NOT:  o_result = ~i_op_a;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_regfile.sv
// 8xN register file, two combinational reads, one synchronous write.
// ALU_ISSUER_R0_ZERO_EN: R0 is hard-wired to zero (writes to it are dropped).
module alu_regfile
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_we,
    input  logic [2:0]   i_wa,
    input  logic [N-1:0] i_wd,
    input  logic [2:0]   i_ra_a,
    input  logic [2:0]   i_ra_b,
    output logic [N-1:0] o_rd_a,
    output logic [N-1:0] o_rd_b
);

    logic [N-1:0] r_mem [8];
    logic         w_wr_en;

`ifdef ALU_ISSUER_R0_ZERO_EN
    // R0 resets to 0 and is never written, so plain reads already return 0.
    assign w_wr_en = i_we && (i_wa != 3'd0);
`else
    assign w_wr_en = i_we;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the whole array is reset because software expects every register to read 0.
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            // NOTE: non-blocking so reads in the same cycle see the old value.
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd_a = r_mem[i_ra_a];
    assign o_rd_b = r_mem[i_ra_b];

endmodule

// File: rtl/alu_issuer.sv
// Single-issue IDLE/EXEC/RESP controller driving the shared ALU with register writeback.
// Optional build macro: ALU_ISSUER_R0_ZERO_EN (R0 reads as zero).
module alu_issuer
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  in_instr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [2:0]   out_rd
);

    issue_state_t r_state;
    issue_state_t w_state_nxt;

    logic [2:0]   r_op;
    logic [2:0]   r_rd;
    logic [N-1:0] r_op_a;
    logic [N-1:0] r_op_b;
    logic [N-1:0] r_result;

    logic [2:0]   w_op;
    logic [2:0]   w_rd;
    logic [2:0]   w_ra;
    logic [2:0]   w_rb;
    logic [9:0]   w_imm;
    logic [N-1:0] w_rf_a;
    logic [N-1:0] w_rf_b;
    logic [N-1:0] w_alu_y;
    logic         w_accept;
    logic         w_unused_bits;

    assign w_op          = in_instr[INSTR_OP_HI:INSTR_OP_LO];
    assign w_rd          = in_instr[INSTR_RD_HI:INSTR_RD_LO];
    assign w_ra          = in_instr[INSTR_RA_HI:INSTR_RA_LO];
    assign w_rb          = in_instr[INSTR_RB_HI:INSTR_RB_LO];
    assign w_imm         = in_instr[INSTR_IMM_HI:INSTR_IMM_LO];
    assign w_unused_bits = &{1'b0, in_instr[3:0]};

    // Gated by rst so the block never advertises readiness while held in reset.
    assign in_ready   = (r_state == ST_IDLE) && !rst;
    assign out_valid  = (r_state == ST_RESP);
    assign out_result = r_result;
    assign out_rd     = r_rd;
    assign w_accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_EXEC;
            ST_EXEC:                w_state_nxt = ST_RESP;
            ST_RESP: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= ALU_ADD;
            r_rd     <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_rd <= w_rd;
                if (w_op == OP_LI) begin
                    r_op   <= ALU_ADD;
                    r_op_a <= N'(w_imm);
                    r_op_b <= '0;
                end else begin
                    r_op   <= w_op;
                    r_op_a <= w_rf_a;
                    r_op_b <= w_rf_b;
                end
            end
            if (r_state == ST_EXEC) begin
                r_result <= w_alu_y;
            end
        end
    end

    alu_regfile #(.N(N)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .i_we   (r_state == ST_EXEC),
        .i_wa   (r_rd),
        .i_wd   (w_alu_y),
        .i_ra_a (w_ra),
        .i_ra_b (w_rb),
        .o_rd_a (w_rf_a),
        .o_rd_b (w_rf_b)
    );

    alu #(.N(N)) u_alu (
        .i_op     (r_op),
        .i_op_a   (r_op_a),
        .i_op_b   (r_op_b),
        .o_result (w_alu_y)
    );

endmodule

// File: tb/tb_alu_issuer.sv
// Scoreboard bench for alu_issuer: expected results queued at accept, compared at output handshake.
module tb_alu_issuer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [2:0]  out_rd;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   first_valid_cyc = 0;
    int   last_hs_cyc = 0;
    int   last_acc_cyc = 0;
    logic prev_valid = 1'b0;
    logic [31:0] held;

    alu_issuer #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 4'b0000};
    endfunction

    function automatic logic [15:0] li(input logic [2:0] rd, input logic [9:0] imm);
        return {OP_LI, rd, imm};
    endfunction

    // Offer one instruction; called in the drive phase (just after a rising edge).
    task automatic send(input logic [15:0] instr, input logic [31:0] res, input logic [2:0] rd);
        int   n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_instr = instr;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            e.res = res;
            e.rd  = rd;
            sb.push_back(e);
            acc_q.push_back(cyc);
            last_acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_instr = 16'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   a;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) first_valid_cyc = cyc;
            prev_valid = out_valid;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    a = acc_q.pop_front();
                    check("result", out_result, e.res);
                    check("out_rd", 32'(out_rd), 32'(e.rd));
                    check("latency", 32'(first_valid_cyc - a), 32'd2);
                end
                last_hs_cyc = cyc;
            end
        end
    end

    initial begin
        // Reset for two cycles.
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_result", out_result, 32'd0);
        check("post_rst_rd", 32'(out_rd), 32'd0);
        @(posedge clk);
        #1;

        send(mk(ALU_ADD, 3'd1, 3'd2, 3'd3), 32'd0, 3'd1);

        // Arithmetic and wrap.
        send(li(3'd1, 10'd5), 32'd5, 3'd1);
        send(li(3'd2, 10'd3), 32'd3, 3'd2);
        send(mk(ALU_SUB, 3'd3, 3'd1, 3'd2), 32'd2, 3'd3);
        send(mk(ALU_SUB, 3'd4, 3'd2, 3'd1), 32'hFFFF_FFFE, 3'd4);
        send(li(3'd5, 10'h3FF), 32'h3FF, 3'd5);
        send(mk(ALU_ADD, 3'd5, 3'd5, 3'd5), 32'h7FE, 3'd5);

        // Compare and logic with r1=5, r2=3, r4=0xFFFFFFFE.
        send(mk(ALU_LESS, 3'd6, 3'd2, 3'd1), 32'd1, 3'd6);
        send(mk(ALU_LESS, 3'd6, 3'd1, 3'd2), 32'd0, 3'd6);
        send(mk(ALU_LESS, 3'd6, 3'd4, 3'd1), 32'd0, 3'd6);
        send(mk(ALU_EQ,   3'd6, 3'd1, 3'd1), 32'd1, 3'd6);
        send(mk(ALU_OR,   3'd7, 3'd1, 3'd2), 32'd7, 3'd7);
        send(mk(ALU_AND,  3'd7, 3'd1, 3'd2), 32'd1, 3'd7);
        send(mk(ALU_NOT,  3'd7, 3'd2, 3'd5), 32'hFFFF_FFFC, 3'd7);

        // Backpressure: result held for 5 cycles while a second instruction waits.
        wait_drain();
        out_ready = 1'b0;
        send(mk(ALU_OR, 3'd7, 3'd1, 3'd2), 32'd7, 3'd7);
        in_valid = 1'b1;
        in_instr = mk(ALU_ADD, 3'd3, 3'd3, 3'd3);
        @(negedge clk);
        check("bp_exec_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        held = out_result;
        check("bp_first_result", out_result, 32'd7);
        repeat (5) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_stable", out_result, held);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(mk(ALU_ADD, 3'd3, 3'd3, 3'd3), 32'd4, 3'd3);
        check("bp_reaccept_gap", 32'(last_acc_cyc - last_hs_cyc), 32'd1);

        // Reset during EXEC drops the instruction and clears the register file.
        wait_drain();
        send(li(3'd1, 10'd9), 32'd9, 3'd1);
        rst = 1'b1;
        void'(sb.pop_back());
        void'(acc_q.pop_back());
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(mk(ALU_ADD, 3'd2, 3'd1, 3'd0), 32'd0, 3'd2);

        // R0 behaviour depends on build configuration.
        send(li(3'd0, 10'd7), 32'd7, 3'd0);
`ifdef ALU_ISSUER_R0_ZERO_EN
        send(mk(ALU_ADD, 3'd1, 3'd0, 3'd0), 32'd0, 3'd1);
`else
        send(mk(ALU_ADD, 3'd1, 3'd0, 3'd0), 32'd14, 3'd1);
`endif
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
